mem_stage: RTL
==============

# mem_stage

Memory-access stage of the MIPS processor, sitting directly upstream of the mem/wb writeback path. It accepts one instruction at a time from execute, performs the data-memory load or store over a request/acknowledge handshake, and applies byte-lane alignment and load sign/zero extension. It then presents a single-cycle writeback result and asserts `stall` while an access is outstanding. Non-memory instructions pass through with their ALU result.

## Interface
Parameters:
- `ADDR_W`, 32, data-memory byte address width.
- `DATA_W`, 32, data word width; only 32 is supported.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `ex_valid`  in  1  execute presents an instruction.
- `ex_ready`  out  1  stage can accept this cycle.
- `ex_op`  in  4  `mem_op_t`: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- `ex_addr`  in  ADDR_W  effective byte address.
- `ex_wdata`  in  32  store data in low bits.
- `ex_result`  in  32  ALU result for NONE ops.
- `ex_rd`  in  5  destination register.
- `ex_reg_we`  in  1  register write enable.
- `dm_req`  out  1  memory request, held until ack.
- `dm_we`  out  1  store when 1.
- `dm_addr`  out  ADDR_W  word-aligned address, with [1:0]=0.
- `dm_be`  out  4  byte enables; bit 3 is bits [31:24].
- `dm_wdata`  out  32  lane-replicated store data.
- `dm_ack`  in  1  access complete; `dm_rdata` is valid in the same cycle.
- `dm_rdata`  in  32  load word.
- `wb_valid`  out  1  one-cycle result pulse.
- `wb_rd`  out  5  destination register.
- `wb_we`  out  1  register write.
- `wb_data`  out  32  writeback value.
- `wb_exc`  out  1  alignment exception.
- `stall`  out  1  upstream must hold.

## Operation
- Byte order is big-endian: byte offset 0 maps to bits [31:24].
- FSM states:
  - IDLE: `ex_ready`=1. An accepted instruction is one with `ex_valid`=1 in IDLE.
    - NONE: go to DONE with `wb_data`=`ex_result`.
    - Load or store: go to ACCESS.
  - ACCESS: `dm_req`=1, with address, enables and data stable, until the cycle `dm_ack`=1. Then go to DONE.
  - DONE: `wb_valid`=1 for exactly one cycle, then go to IDLE.
- On ack, load data is captured from `dm_rdata`:
  - LB/LBU: select the addressed byte, then sign-extend (LB) or zero-extend (LBU).
  - LH/LHU: select the halfword by `addr[1]`, then sign-extend (LH) or zero-extend (LHU).
  - LW: pass the word through.
- Store byte enables:
  - SB: one-hot by offset, e.g. offset 0 gives 4'b1000. Data byte is replicated to all four lanes.
  - SH: 4'b1100 or 4'b0011. Halfword is replicated to both halves.
  - SW: 4'b1111.
- Loads use `dm_be`=4'b1111.
- Stores never write a register: `wb_we`=0, regardless of `ex_reg_we`.
- `stall` = (state != IDLE).
- `ex_ready` = (state == IDLE) and `rst` deasserted.

## Timing
- Reset (`rst`=0 at an edge): state goes to IDLE. `dm_req`, `dm_we`, `dm_be`, `wb_valid`, `wb_we`, `wb_exc` = 0; `dm_addr`, `dm_wdata`, `wb_data`, `wb_rd` = 0. `stall`=0 and `ex_ready`=0 while in reset.
- NONE op: `wb_valid` in the cycle after acceptance (latency 1).
- Memory op:
  - `dm_req` rises in the cycle after acceptance.
  - Zero-wait ack (ack in the first request cycle) gives `wb_valid` two cycles after acceptance.
  - Each additional wait cycle adds one cycle.
- `dm_ack` is ignored outside ACCESS.
- Reset during ACCESS: `dm_req` drops at that edge and no `wb_valid` is produced for the aborted access.
- `ex_valid` during ACCESS or DONE is not accepted. Execute holds it, since `stall`=1.
- No back-to-back acceptance: at most one instruction every two cycles.

## Configuration
- `MEM_STAGE_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0, go from IDLE directly to DONE.
  - No `dm_req` is issued.
  - Result is `wb_exc`=1, `wb_we`=0, `wb_data`=faulting address.
- Undefined:
  - Offending low address bits are ignored: halfwords use `addr[1]` only, words use neither.
  - `wb_exc` is tied 0.

## Structure
- `mem_stage_pkg`: `mem_op_t` enum, FSM state enum, byte-enable constants `BE_B0`..`BE_B3`, `BE_H0`, `BE_H1`, `BE_W`.
- Sub-module `load_store_align` (combinational):
  - Store side: op and offset in, byte enables and replicated data out.
  - Load side: op, offset and raw word in, extended data out.

## Test plan
- LW at 0x100, `dm_rdata`=0xDEADBEEF, ack in first request cycle → `dm_be`=4'b1111; `wb_data`=0xDEADBEEF with `wb_valid` 2 cycles after acceptance.
- LB at 0x103, word 0x000000F0 → `wb_data`=0xFFFFFFF0. LBU at the same address → 0x000000F0.
- SH at 0x202, `ex_wdata`=0x1234, ack after 3 wait cycles → `dm_be`=4'b0011; `dm_wdata`=0x12341234 held steady for 4 cycles; `stall`=1 throughout; `wb_we`=0.
- NONE op, `ex_result`=0x55 → `wb_valid` next cycle; `wb_data`=0x55; `dm_req` never asserted.
- `rst`=0 asserted on the second wait cycle of SW → `dm_req`=0 at the next edge; no `wb_valid`; a later ack is ignored.
- With `MEM_STAGE_MISALIGN_TRAP_EN`: LW at 0x101 → no `dm_req`; `wb_exc`=1 and `wb_data`=0x101 in the next cycle. Without the macro: LW at 0x101 → `dm_addr`=0x100.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and byte-lane constants for the MIPS memory-access stage.
// Big-endian lanes: byte offset 0 lives in bits [31:24], which is enable bit 3.
package mem_stage_pkg;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LBU  = 4'd2,
      OP_LH   = 4'd3,
      OP_LHU  = 4'd4,
      OP_LW   = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } mem_op_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [3:0] BE_B0 = 4'b1000;
   localparam logic [3:0] BE_B1 = 4'b0100;
   localparam logic [3:0] BE_B2 = 4'b0010;
   localparam logic [3:0] BE_B3 = 4'b0001;
   localparam logic [3:0] BE_H0 = 4'b1100;
   localparam logic [3:0] BE_H1 = 4'b0011;
   localparam logic [3:0] BE_W  = 4'b1111;

   function automatic logic is_store(input mem_op_t op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] offset);
      case (op)
         OP_LH, OP_LHU, OP_SH: return offset[0];
         OP_LW, OP_SW:         return offset != 2'b00;
         default:              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering: store enables/replication and load
// lane selection with sign or zero extension.
module load_store_align
   import mem_stage_pkg::*;
(
   input  logic [3:0]  st_op,
   input  logic [1:0]  st_offset,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [3:0]  ld_op,
   input  logic [1:0]  ld_offset,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      st_be    = BE_W;
      st_wdata = st_data;
      case (mem_op_t'(st_op))
         OP_SB: begin
            st_wdata = {4{st_data[7:0]}};
            case (st_offset)
               2'd0:    st_be = BE_B0;
               2'd1:    st_be = BE_B1;
               2'd2:    st_be = BE_B2;
               default: st_be = BE_B3;
            endcase
         end
         OP_SH: begin
            st_wdata = {2{st_data[15:0]}};
            st_be    = st_offset[1] ? BE_H1 : BE_H0;
         end
         default: ;
      endcase
   end

   // Halfwords only look at offset[1]; a stray offset[0] is either trapped upstream or ignored.
   always_comb begin
      case (ld_offset)
         2'd0:    byte_sel = ld_word[31:24];
         2'd1:    byte_sel = ld_word[23:16];
         2'd2:    byte_sel = ld_word[15:8];
         default: byte_sel = ld_word[7:0];
      endcase
      half_sel = ld_offset[1] ? ld_word[15:0] : ld_word[31:16];
      case (mem_op_t'(ld_op))
         OP_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  ld_data = {24'd0, byte_sel};
         OP_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  ld_data = {16'd0, half_sel};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: one instruction at a time over a req/ack data port.
// Define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [3:0]        ex_op,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [31:0]       ex_wdata,
   input  logic [31:0]       ex_result,
   input  logic [4:0]        ex_rd,
   input  logic              ex_reg_we,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [3:0]        dm_be,
   output logic [31:0]       dm_wdata,
   input  logic              dm_ack,
   input  logic [31:0]       dm_rdata,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic              wb_we,
   output logic [31:0]       wb_data,
   output logic              wb_exc,
   output logic              stall
);

   state_t      state;
   logic [3:0]  op_q;
   logic [1:0]  offset_q;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;
   logic [31:0] addr_word;
   logic        trap;
   mem_op_t     ex_op_e;

   assign ex_op_e   = mem_op_t'(ex_op);
   assign addr_word = 32'(ex_addr);
   assign ex_ready  = rst && (state == ST_IDLE);
   assign stall     = rst && (state != ST_IDLE);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   assign trap = is_misaligned(ex_op_e, ex_addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   load_store_align u_align (
      .st_op     (ex_op),
      .st_offset (ex_addr[1:0]),
      .st_data   (ex_wdata),
      .st_be     (st_be),
      .st_wdata  (st_wdata),
      .ld_op     (op_q),
      .ld_offset (offset_q),
      .ld_word   (dm_rdata),
      .ld_data   (ld_data)
   );

   // Request fields are captured at acceptance and held untouched until ack.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         op_q     <= OP_NONE;
         offset_q <= 2'd0;
         dm_req   <= 1'b0;
         dm_we    <= 1'b0;
         dm_addr  <= '0;
         dm_be    <= 4'd0;
         dm_wdata <= 32'd0;
         wb_valid <= 1'b0;
         wb_rd    <= 5'd0;
         wb_we    <= 1'b0;
         wb_data  <= 32'd0;
         wb_exc   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ex_valid) begin
                  wb_rd    <= ex_rd;
                  op_q     <= ex_op;
                  offset_q <= ex_addr[1:0];
                  wb_exc   <= 1'b0;
                  if (trap) begin
                     state    <= ST_DONE;
                     wb_valid <= 1'b1;
                     wb_exc   <= 1'b1;
                     wb_we    <= 1'b0;
                     wb_data  <= addr_word;
                  end else if (ex_op_e == OP_NONE) begin
                     state    <= ST_DONE;
                     wb_valid <= 1'b1;
                     wb_we    <= ex_reg_we;
                     wb_data  <= ex_result;
                  end else begin
                     state    <= ST_ACCESS;
                     dm_req   <= 1'b1;
                     dm_we    <= is_store(ex_op_e);
                     dm_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
                     dm_be    <= is_store(ex_op_e) ? st_be : BE_W;
                     dm_wdata <= st_wdata;
                     wb_we    <= ex_reg_we && !is_store(ex_op_e);
                  end
               end
            end
            ST_ACCESS: begin
               if (dm_ack) begin
                  state    <= ST_DONE;
                  dm_req   <= 1'b0;
                  dm_we    <= 1'b0;
                  wb_valid <= 1'b1;
                  if (!is_store(mem_op_t'(op_q)))
                     wb_data <= ld_data;
               end
            end
            ST_DONE: begin
               state    <= ST_IDLE;
               wb_valid <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
